uart_rx_param: RTL

Parametrised UART receive engine. It is the next-generation replacement for the fixed 8-bit, fixed-rate serial-to-parallel path in the UART DUT. It adds:
- configurable data width, oversampling rate, parity mode and stop-bit count
- majority-vote sampling and false-start rejection
- parity, framing and overrun error reporting
- a valid/ready output handshake with a one-entry holding register

---
 rtl/uart_rx_param.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with 2-of-3 majority voting, configurable
// frame format, parity/framing/overrun reporting and a one-entry valid/ready register.
module uart_rx_param #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 SerDataIn,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam int MID   = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_S0    = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] CNT_S1    = CNT_W'(MID);
    localparam logic [CNT_W-1:0] CNT_DEC   = CNT_W'(MID + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic parity_error(input logic [DATA_BITS-1:0] d, input logic p);
        logic x;
        x = (^d) ^ p;
        if (PARITY_MODE == 1) begin
            return x;
        end else if (PARITY_MODE == 2) begin
            return ~x;
        end else begin
            return 1'b0;
        end
    endfunction

    logic                 sync1_r, sync2_r, prev_r;
    state_t               state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [IDX_W-1:0]     idx_r;
    logic                 stop_idx_r;
    logic                 samp0_r, samp1_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 par_r;
    logic                 ferr_r;
    logic                 busy_r;
    logic [DATA_BITS-1:0] rx_data_r;
    logic                 rx_valid_r;
    logic                 parity_err_r;
    logic                 frame_err_r;
    logic                 overrun_r;

    logic fall_s, at_dec_s, at_end_s, vote_s, complete_s;
    logic frame_err_s, parity_err_s, accept_s;

    // Decision-point decode, majority vote and completion qualifiers
    always_comb begin
        fall_s       = prev_r & ~sync2_r;
        at_dec_s     = (cnt_r == CNT_DEC);
        at_end_s     = (cnt_r == CNT_LAST);
        vote_s       = majority3(samp0_r, samp1_r, sync2_r);
        complete_s   = (state_r == STOP) && at_dec_s && (stop_idx_r == STOP_LAST);
        frame_err_s  = ferr_r | ~vote_s;
        parity_err_s = parity_error(shift_r, par_r);
        accept_s     = ~rx_valid_r | rx_ready;
    end

    // Frame sequencer: synchroniser, bit timing, sampling and state transitions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r    <= 1'b1;
            sync2_r    <= 1'b1;
            prev_r     <= 1'b1;
            state_r    <= IDLE;
            cnt_r      <= '0;
            idx_r      <= '0;
            stop_idx_r <= 1'b0;
            samp0_r    <= 1'b1;
            samp1_r    <= 1'b1;
            shift_r    <= '0;
            par_r      <= 1'b0;
            ferr_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            sync1_r <= SerDataIn;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            if (cnt_r == CNT_S0) samp0_r <= sync2_r;
            if (cnt_r == CNT_S1) samp1_r <= sync2_r;
            case (state_r)
                IDLE: begin
                    cnt_r <= '0;
                    // The edge-detect cycle itself is bit cycle 0
                    if (fall_s) begin
                        state_r    <= START;
                        cnt_r      <= CNT_ONE;
                        idx_r      <= '0;
                        stop_idx_r <= 1'b0;
                        ferr_r     <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                START: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    if (at_dec_s && vote_s) begin
                        state_r <= IDLE;
                        cnt_r   <= '0;
                        busy_r  <= 1'b0;
                    end else if (at_end_s) begin
                        state_r <= DATA;
                        cnt_r   <= '0;
                        idx_r   <= '0;
                    end
                end
                DATA: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    if (at_dec_s) shift_r[idx_r] <= vote_s;
                    if (at_end_s) begin
                        cnt_r <= '0;
                        if (idx_r == IDX_LAST) begin
                            state_r <= (PARITY_MODE != 0) ? PARITY : STOP;
                        end else begin
                            idx_r <= idx_r + IDX_ONE;
                        end
                    end
                end
                PARITY: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    if (at_dec_s) par_r <= vote_s;
                    if (at_end_s) begin
                        state_r <= STOP;
                        cnt_r   <= '0;
                    end
                end
                STOP: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    // Last stop bit completes at its decision point to re-arm early
                    if (complete_s) begin
                        state_r <= frame_err_s ? WAIT_HIGH : IDLE;
                        busy_r  <= frame_err_s;
                        cnt_r   <= '0;
                    end else begin
                        if (at_dec_s && !vote_s) ferr_r <= 1'b1;
                        if (at_end_s) begin
                            cnt_r      <= '0;
                            stop_idx_r <= 1'b1;
                        end
                    end
                end
                WAIT_HIGH: begin
                    cnt_r <= '0;
                    if (sync2_r) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Holding register: load on completion when free or draining, otherwise flag overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_r    <= '0;
            rx_valid_r   <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            overrun_r <= 1'b0;
            if (complete_s) begin
                if (accept_s) begin
                    rx_data_r    <= shift_r;
                    rx_valid_r   <= 1'b1;
                    parity_err_r <= parity_err_s;
                    frame_err_r  <= frame_err_s;
                end else begin
                    overrun_r <= 1'b1;
                end
            end else if (rx_valid_r && rx_ready) begin
                rx_valid_r <= 1'b0;
            end
        end
    end

    assign rx_data    = rx_data_r;
    assign rx_valid   = rx_valid_r;
    assign parity_err = parity_err_r;
    assign frame_err  = frame_err_r;
    assign overrun    = overrun_r;
    assign busy       = busy_r;

endmodule
